// File: rtl/afifo_defines.sv
// rtl/afifo_defines.sv - shared defaults, occupancy encoding and credit helper for the read-side drain
package afifo_defines;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Skid-buffer fill level doubles as the buffer state encoding.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // True when a new read can be issued without overflowing the buffer:
    // words already held plus the one in flight, minus the one leaving now,
    // must leave at least one free slot.
    function automatic logic credit_ok(
        input logic [1:0] occ,
        input logic       pending,
        input logic       pop
    );
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
        return (committed < 3'd2);
    endfunction

endpackage

// File: rtl/afifo_skid_buf.sv
// rtl/afifo_skid_buf.sv - two-entry circular skid buffer with push/pop and fill level
module afifo_skid_buf
    import afifo_defines::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            occupancy
);

    occ_e                  r_state;
    occ_e                  w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_head;
    logic                  r_tail;
    logic                  w_pop;

    // A pop is only meaningful while something is held; ignore it otherwise.
    assign w_pop = pop & (r_state != EMPTY);

    assign valid     = (r_state != EMPTY);
    assign data      = r_mem[r_head];
    assign occupancy = r_state;

    // Fill-level state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill-level transitions; the upstream credit rule keeps push out of FULL unless paired with a pop.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (push) begin
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && !w_pop) begin
                    w_state_nxt = FULL;
                end else if (w_pop && !push) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop && !push) begin
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // Storage and pointers: push writes at the tail, pop advances the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 1'b0;
            r_tail <= 1'b0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

endmodule

// File: rtl/afifo_rd_drain.sv
// rtl/afifo_rd_drain.sv - turns the async FIFO read port into a valid/ready stream with a delivered-word count
module afifo_rd_drain
    import afifo_defines::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  pop_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_pending;
    logic [CNT_WIDTH-1:0] r_pop_cnt;
    logic                 w_pop;
    logic                 w_rd_en;
    logic                 w_valid;
    logic [1:0]           w_occ;

    assign w_pop = w_valid & m_ready;

    // Read only when the word will have a guaranteed slot on arrival; held off during reset
    // so the FIFO never loses a word to a read that would be discarded.
    assign w_rd_en = ~rst & en & ~empty & credit_ok(w_occ, r_pending, w_pop);

    assign rd_en     = w_rd_en;
    assign m_valid   = w_valid;
    assign occupancy = w_occ;
    assign pop_cnt   = r_pop_cnt;

    // Track the read in flight: its data shows up on rdata next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_rd_en;
        end
    end

    // Count words handed downstream, wrapping naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_cnt <= '0;
        end else if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + CNT_ONE;
        end
    end

    afifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pending),
        .push_data (rdata),
        .pop       (w_pop),
        .valid     (w_valid),
        .data      (m_data),
        .occupancy (w_occ)
    );

endmodule

// File: tb/tb_afifo_rd_drain.sv
// tb/tb_afifo_rd_drain.sv - self-checking bench for the FIFO read-side drain
module tb_afifo_rd_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        empty;
    logic        m_ready;
    logic [7:0]  rdata = 8'h00;

    logic        rd_en_a, rd_en_b;
    logic        m_valid_a, m_valid_b;
    logic [7:0]  m_data_a, m_data_b;
    logic [1:0]  occ_a, occ_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [0:255];
    int         wptr = 0;
    int         rptr = 0;
    logic [7:0] exp_q [$];

    logic       hold_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_v;
        logic [7:0]  exp_d;
        logic [1:0]  exp_occ;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [20];

    always #5 clk = ~clk;

    afifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .rd_en(rd_en_a), .rdata(rdata),
        .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready),
        .occupancy(occ_a), .pop_cnt(cnt_a)
    );

    afifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .rd_en(rd_en_b), .rdata(rdata),
        .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready),
        .occupancy(occ_b), .pop_cnt(cnt_b)
    );

    // FIFO model: one-cycle read latency
    assign empty = (rptr == wptr);

    always @(posedge clk) begin
        if (rd_en_a) begin
            rdata <= fifo_mem[rptr[7:0]];
            rptr  <= rptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input bit expect_out);
        fifo_mem[wptr[7:0]] = d;
        wptr++;
        if (expect_out) exp_q.push_back(d);
    endtask

    // All tasks enter and leave at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input int mode, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid_a) && n < budget) begin
            en = 1'b1;
            m_ready = (mode == 0) ? 1'b1 : ((n % 2) == 0);
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        chk("drain_in_budget", (n < budget), 1);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            en = tbl[i].en;
            m_ready = tbl[i].rdy;
            #2;
            chk($sformatf("row%0d_rd_en", i), rd_en_a, tbl[i].exp_rd);
            chk($sformatf("row%0d_m_valid", i), m_valid_a, tbl[i].exp_v);
            if (tbl[i].exp_v) chk($sformatf("row%0d_m_data", i), m_data_a, tbl[i].exp_d);
            chk($sformatf("row%0d_occupancy", i), occ_a, tbl[i].exp_occ);
            chk($sformatf("row%0d_pop_cnt", i), cnt_a, tbl[i].exp_cnt);
            @(negedge clk);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic r, input logic rd, input logic v,
                                input logic [7:0] d, input logic [1:0] o, input logic [15:0] c);
        vec_t t;
        t.en = e; t.rdy = r; t.exp_rd = rd; t.exp_v = v;
        t.exp_d = d; t.exp_occ = o; t.exp_cnt = c;
        return t;
    endfunction

    // Scoreboard and protocol properties, sampled mid low phase
    always @(negedge clk) begin
        #3;
        if (rst === 1'b0) begin
            if (rd_en_b !== rd_en_a) chk("rd_en_lockstep", rd_en_b, rd_en_a);
            if (rd_en_a) chk("rd_en_implies_not_empty", empty, 0);
            if (occ_a > 2'd2) chk("occupancy_bound", occ_a, 2);
            if (hold_prev) begin
                chk("m_data_stable", m_data_a, data_prev);
                chk("m_valid_held", m_valid_a, 1);
            end
            if (m_valid_a && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none", m_data_a);
                end else begin
                    chk("stream_order", m_data_a, exp_q.pop_front());
                end
            end
            hold_prev = m_valid_a && !m_ready;
            data_prev = m_data_a;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // basic stream, m_ready held high
        tbl[0]  = mk(1, 1, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 8'h11, 1, 0);
        tbl[3]  = mk(1, 1, 0, 1, 8'h22, 1, 1);
        tbl[4]  = mk(1, 1, 0, 1, 8'h33, 1, 2);
        tbl[5]  = mk(1, 1, 0, 0, 8'h00, 0, 3);
        // backpressure fills the buffer, then release
        tbl[6]  = mk(1, 0, 1, 0, 8'h00, 0, 0);
        tbl[7]  = mk(1, 0, 1, 0, 8'h00, 0, 0);
        tbl[8]  = mk(1, 0, 0, 1, 8'hA0, 1, 0);
        tbl[9]  = mk(1, 0, 0, 1, 8'hA0, 2, 0);
        tbl[10] = mk(1, 0, 0, 1, 8'hA0, 2, 0);
        tbl[11] = mk(1, 1, 1, 1, 8'hA0, 2, 0);
        tbl[12] = mk(1, 1, 1, 1, 8'hA1, 1, 1);
        tbl[13] = mk(1, 1, 1, 1, 8'hA2, 1, 2);
        tbl[14] = mk(1, 1, 1, 1, 8'hA3, 1, 3);
        tbl[15] = mk(1, 1, 1, 1, 8'hA4, 1, 4);
        tbl[16] = mk(1, 1, 1, 1, 8'hA5, 1, 5);
        tbl[17] = mk(1, 1, 0, 1, 8'hA6, 1, 6);
        tbl[18] = mk(1, 1, 0, 1, 8'hA7, 1, 7);
        tbl[19] = mk(1, 1, 0, 0, 8'h00, 0, 8);

        rst = 1'b1;
        en = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_rd_en", rd_en_a, 0);
        chk("reset_m_valid", m_valid_a, 0);
        chk("reset_m_data", m_data_a, 0);
        chk("reset_occupancy", occ_a, 0);
        chk("reset_pop_cnt", cnt_a, 0);
        @(negedge clk);

        // three words, free-flowing
        do_reset();
        push_word(8'h11, 1); push_word(8'h22, 1); push_word(8'h33, 1);
        run_rows(0, 5);
        chk("t1_all_delivered", exp_q.size(), 0);

        // eight words with initial backpressure
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i), 1);
        run_rows(6, 19);
        chk("t2_all_delivered", exp_q.size(), 0);

        // sixteen words, m_ready alternating
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'(i), 1);
        drain(1, 200);
        chk("t3_pop_cnt", cnt_a, 16);
        chk("t3_all_delivered", exp_q.size(), 0);

        // reset lands while a read is in flight
        do_reset();
        push_word(8'h55, 0);
        en = 1'b1;
        m_ready = 1'b1;
        #2;
        chk("t4_read_issued", rd_en_a, 1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("t4_rd_en_in_reset", rd_en_a, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t4_m_valid", m_valid_a, 0);
            chk("t4_occupancy", occ_a, 0);
            chk("t4_pop_cnt", cnt_a, 0);
            chk("t4_m_data", m_data_a, 0);
            @(negedge clk);
        end

        // drain enable gating
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i), 1);
        for (int i = 0; i < 4; i++) begin
            en = 1'b0;
            m_ready = 1'b1;
            #2;
            chk("t5_rd_en_gated", rd_en_a, 0);
            chk("t5_m_valid_gated", m_valid_a, 0);
            @(negedge clk);
        end
        en = 1'b1;
        #2;
        chk("t5_rd_en_resume", rd_en_a, 1);
        chk("t5_m_valid_n", m_valid_a, 0);
        @(negedge clk);
        #2;
        chk("t5_m_valid_n1", m_valid_a, 0);
        @(negedge clk);
        #2;
        chk("t5_m_valid_n2", m_valid_a, 1);
        chk("t5_m_data_n2", m_data_a, 8'hC0);
        @(negedge clk);
        drain(0, 50);
        chk("t5_pop_cnt", cnt_a, 4);

        // counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) push_word(8'h30 + 8'(i), 1);
        drain(0, 100);
        chk("t6_pop_cnt_wide", cnt_a, 17);
        chk("t6_pop_cnt_wrap", cnt_b, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
